// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR width default and maximal-length tap table
package lfsr_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit i set means register bit i feeds the feedback XOR; 0 flags an unsupported width.
  function automatic logic [31:0] max_taps(int width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// rtl/lfsr_feedback.sv - combinational parity of the tapped register bits
module lfsr_feedback #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
  input  logic [WIDTH-1:0] q,
  output logic             fb
);

  assign fb = ^(q & TAPS);

endmodule

// File: rtl/lfsr.sv
// rtl/lfsr.sv - Fibonacci LFSR with seed load on synchronous active-low reset
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_pkg::max_taps(WIDTH)),
  parameter logic [WIDTH-1:0] ZERO_SUB = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] shift_seed
);

  logic [WIDTH-1:0] q;
  logic             fb;

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr: WIDTH must be within 3..32");
  end
  if (TAPS == '0 || TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr: TAPS must be nonzero and include the top register bit");
  end

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .q  (q),
    .fb (fb)
  );

  // An all-zero seed would lock the register, so it is replaced on load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= (seed == '0) ? ZERO_SUB : seed;
    end else begin
      q <= {q[WIDTH-2:0], fb};
    end
  end

  assign shift_seed = q;

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - randomized self-checking bench for lfsr against a polynomial model
module tb_lfsr;

  logic       clk = 1'b0;
  logic       rst8 = 1'b0;
  logic       rst4 = 1'b0;
  logic [7:0] seed8 = 8'h00;
  logic [3:0] seed4 = 4'h0;
  logic [7:0] q8;
  logic [3:0] q4;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m8;
  logic [31:0] m4;

  always #5 clk = ~clk;

  lfsr #(.WIDTH(8)) u_lfsr8 (
    .clk        (clk),
    .reset      (rst8),
    .seed       (seed8),
    .shift_seed (q8)
  );

  lfsr #(.WIDTH(4)) u_lfsr4 (
    .clk        (clk),
    .reset      (rst4),
    .seed       (seed4),
    .shift_seed (q4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial step: new low bit is the parity of tapped bits, shifted in from the right.
  function automatic logic [31:0] poly_step(input logic [31:0] s, input int w, input logic [31:0] taps);
    int fb;
    fb = $countones(s & taps) % 2;
    return ((s << 1) | 32'(fb)) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    m8 = !rst8 ? ((seed8 == 8'h00) ? 32'h01 : {24'h0, seed8}) : poly_step(m8, 8, 32'hB8);
    m4 = !rst4 ? ((seed4 == 4'h0) ? 32'h1 : {28'h0, seed4}) : poly_step(m4, 4, 32'hC);
    #1;
    check("model8", {24'h0, q8}, m8);
    check("model4", {28'h0, q4}, m4);
  endtask

  task automatic load8(input logic [7:0] s, input int cycles);
    rst8 = 1'b0;
    seed8 = s;
    repeat (cycles) tick();
    rst8 = 1'b1;
  endtask

  initial begin
    int seen8 [256];
    int seen4 [16];
    int n;
    int distinct;
    int zeros;
    logic [7:0] exp_seq [6];

    // Seed A5 held in reset for two edges, then two advances.
    load8(8'hA5, 2);
    rst4 = 1'b0;
    check("reset_a5", {24'h0, q8}, 32'hA5);
    tick();
    check("a5_step1", {24'h0, q8}, 32'h4A);
    tick();
    check("a5_step2", {24'h0, q8}, 32'h95);

    // Known sequence from seed 01.
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    load8(8'h01, 1);
    check("reset_01", {24'h0, q8}, 32'h01);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq_01", {24'h0, q8}, {24'h0, exp_seq[i]});
    end

    // Full period from 01: every nonzero value exactly once.
    load8(8'h01, 1);
    foreach (seen8[i]) seen8[i] = 0;
    n = 0;
    do begin
      seen8[q8]++;
      tick();
      n++;
    end while (q8 != 8'h01 && n < 300);
    check("period8", n, 255);
    distinct = 0;
    for (int v = 1; v < 256; v++) if (seen8[v] == 1) distinct++;
    check("distinct8", distinct, 255);
    check("zero_seen8", seen8[0], 0);

    // Zero seed substitution and no lock-up.
    load8(8'h00, 1);
    check("zero_sub", {24'h0, q8}, 32'h01);
    zeros = 0;
    repeat (300) begin
      tick();
      if (q8 == 8'h00) zeros++;
    end
    check("zero_reached", zeros, 0);

    // Seed wiggling while running is ignored; the model ignores it too.
    load8(8'($urandom_range(1, 255)), 1);
    repeat (40) begin
      seed8 = 8'($urandom);
      tick();
    end
    seed8 = 8'h3C;
    repeat (3) tick();
    rst8 = 1'b0;
    tick();
    check("mid_reset_3c", {24'h0, q8}, 32'h3C);
    rst8 = 1'b1;
    tick();
    check("restart_3c", {24'h0, q8}, 32'h79);

    // Random reset pulses, seeds and run lengths.
    for (int k = 0; k < 20; k++) begin
      load8(8'($urandom), $urandom_range(1, 3));
      repeat ($urandom_range(1, 30)) begin
        if ($urandom_range(0, 7) == 0) seed8 = 8'($urandom);
        tick();
      end
    end

    // Width-4 instance: period 15, all nonzero states.
    seed4 = 4'h1;
    rst4 = 1'b0;
    tick();
    rst4 = 1'b1;
    check("reset4", {28'h0, q4}, 32'h1);
    foreach (seen4[i]) seen4[i] = 0;
    n = 0;
    do begin
      seen4[q4]++;
      tick();
      n++;
    end while (q4 != 4'h1 && n < 40);
    check("period4", n, 15);
    distinct = 0;
    for (int v = 1; v < 16; v++) if (seen4[v] == 1) distinct++;
    check("distinct4", distinct, 15);
    check("zero_seen4", seen4[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
